// File: rtl/cacheline_adaptor_if.sv
// Line-side and burst-side signal bundle for cacheline_adaptor.
// Handshake semantics: line_read/line_write are held by the arbiter until line_resp
// pulses for one cycle; burst_read/burst_write are held by the adaptor, and memory
// moves one beat on every cycle it drives burst_resp high.
interface cacheline_adaptor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] line_address;
  logic                  line_read;
  logic                  line_write;
  logic [LINE_WIDTH-1:0] line_wdata;
  logic                  line_resp;
  logic [LINE_WIDTH-1:0] line_rdata;
  logic [ADDR_WIDTH-1:0] burst_address;
  logic                  burst_read;
  logic                  burst_write;
  logic [BEAT_WIDTH-1:0] burst_wdata;
  logic [BEAT_WIDTH-1:0] burst_rdata;
  logic                  burst_resp;

  modport slave (
    input  line_address, line_read, line_write, line_wdata, burst_rdata, burst_resp,
    output line_resp, line_rdata, burst_address, burst_read, burst_write, burst_wdata
  );

  modport master (
    output line_address, line_read, line_write, line_wdata, burst_rdata, burst_resp,
    input  line_resp, line_rdata, burst_address, burst_read, burst_write, burst_wdata
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one cacheline read/write into a multi-beat burst to physical memory.
// Reads are assembled into a line buffer; writes are latched and streamed out.
module cacheline_adaptor #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  cacheline_adaptor_if.slave bus,
  output logic [1:0]        state_o
);
  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} state_e;

  state_e                           state_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [CNT_W-1:0]                 cnt_d;
  logic [ADDR_WIDTH-1:0]            addr_q;
  logic [ADDR_WIDTH-1:0]            addr_d;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] wbuf_q;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] rbuf_q;
  logic                             rd_q;
  logic                             wr_q;
  logic                             resp_q;

  assign addr_d = {bus.line_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign cnt_d  = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Read has priority; a simultaneous write is dropped.
          if (bus.line_read) begin
            addr_q  <= addr_d;
            cnt_q   <= '0;
            rd_q    <= 1'b1;
            state_q <= RD_BURST;
          end else if (bus.line_write) begin
            addr_q  <= addr_d;
            wbuf_q  <= bus.line_wdata;
            cnt_q   <= '0;
            wr_q    <= 1'b1;
            state_q <= WR_BURST;
          end
        end
        RD_BURST: begin
          if (bus.burst_resp) begin
            rbuf_q[cnt_q] <= bus.burst_rdata;
            cnt_q         <= cnt_d;
            if (cnt_q == LAST_BEAT) begin
              rd_q    <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        WR_BURST: begin
          if (bus.burst_resp) begin
            cnt_q <= cnt_d;
            if (cnt_q == LAST_BEAT) begin
              wr_q    <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.line_resp     = resp_q;
  assign bus.line_rdata    = rbuf_q;
  assign bus.burst_address = addr_q;
  assign bus.burst_read    = rd_q;
  assign bus.burst_write   = wr_q;
  assign bus.burst_wdata   = wbuf_q[cnt_q];
  assign state_o           = state_q;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: a transaction-level model predicts every
// output each cycle, and literal expectations pin the model.
module tb_cacheline_adaptor;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int NB = LW / BW;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_resp  = 0;
  int exp_resp = 0;

  cacheline_adaptor_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW)) bus ();

  cacheline_adaptor #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Transaction-level model: which transfer is open, how many beats moved, and
  // whether the one-cycle response is due.
  int           m_kind  = 0;  // 0 none, 1 read, 2 write
  int           m_beats = 0;
  bit           m_resp  = 0;
  bit           m_valid = 0;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wline;
  logic [LW-1:0] m_rline;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_kind = 0; m_beats = 0; m_resp = 0;
      m_addr = '0; m_wline = '0; m_rline = '0;
      m_valid = 1;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_kind == 0) begin
      if (bus.line_read || bus.line_write) begin
        m_kind  = bus.line_read ? 1 : 2;
        m_addr  = bus.line_address & ~32'h1F;
        m_beats = 0;
        if (!bus.line_read) m_wline = bus.line_wdata;
      end
    end else if (bus.burst_resp) begin
      if (m_kind == 1) m_rline[m_beats*BW +: BW] = bus.burst_rdata;
      m_beats++;
      if (m_beats == NB) begin
        m_kind = 0;
        m_resp = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("line_resp", bus.line_resp, m_resp);
      chk("burst_read", bus.burst_read, m_kind == 1);
      chk("burst_write", bus.burst_write, m_kind == 2);
      chk("burst_address", bus.burst_address, m_addr);
      chk("line_rdata", bus.line_rdata, m_rline);
      if (m_kind == 2) chk("burst_wdata", bus.burst_wdata, m_wline[m_beats*BW +: BW]);
      if (bus.line_resp) n_resp++;
    end
  end

  // Called at posedge+2; returns at posedge+2 with the request dropped.
  task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr,
                        input logic [LW-1:0] wline, input logic [LW-1:0] rbeats, input int gap);
    int t_sample;
    bus.line_read    = !wr;
    bus.line_write   = wr;
    bus.line_address = addr;
    bus.line_wdata   = wline;
    t_sample = cyc + 1;
    @(posedge clk); #2;
    bus.line_address = $urandom;
    bus.line_wdata   = {8{$urandom}};
    chk("start_addr", bus.burst_address, exp_addr);
    chk("start_read", bus.burst_read, !wr);
    chk("start_write", bus.burst_write, wr);
    for (int k = 0; k < NB; k++) begin
      if (k > 0) begin
        repeat (gap) begin
          bus.burst_resp  = 1'b0;
          bus.burst_rdata = {$urandom, $urandom};
          @(posedge clk); #2;
        end
      end
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = rbeats[k*BW +: BW];
      if (wr) chk("wr_beat", bus.burst_wdata, wline[k*BW +: BW]);
      @(posedge clk); #2;
    end
    bus.burst_resp = 1'b0;
    chk("resp_after_last_beat", bus.line_resp, 1'b1);
    if (gap == 0) chk("resp_latency_edges", cyc - t_sample, 4);
    exp_resp++;
    @(posedge clk); #2;
    chk("resp_one_cycle", bus.line_resp, 1'b0);
    bus.line_read  = 1'b0;
    bus.line_write = 1'b0;
  endtask

  localparam logic [LW-1:0] LINE1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [LW-1:0] WLINE = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                                     64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
  localparam logic [LW-1:0] LINE3 = {64'hA5A5_0000_0000_0004, 64'hA5A5_0000_0000_0003,
                                     64'hA5A5_0000_0000_0002, 64'hA5A5_0000_0000_0001};
  localparam logic [LW-1:0] LINE4 = {64'h0BAD_F00D_0000_0004, 64'h0BAD_F00D_0000_0003,
                                     64'h0BAD_F00D_0000_0002, 64'h0BAD_F00D_0000_0001};
  localparam logic [LW-1:0] LINE6 = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                                     64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};
  localparam logic [LW-1:0] LINE7 = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
                                     64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};

  initial begin
    logic [LW-1:0] noise;
    rst = 1'b1;
    bus.line_address = '0; bus.line_read = 1'b0; bus.line_write = 1'b0;
    bus.line_wdata = '0; bus.burst_rdata = '0; bus.burst_resp = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_line_resp", bus.line_resp, 1'b0);
    chk("rst_burst_read", bus.burst_read, 1'b0);
    chk("rst_burst_write", bus.burst_write, 1'b0);
    chk("rst_burst_address", bus.burst_address, '0);
    chk("rst_line_rdata", bus.line_rdata, '0);
    chk("rst_burst_wdata", bus.burst_wdata, '0);
    rst = 1'b0;
    @(posedge clk); #2;

    // 1: aligned read, back-to-back beats
    do_txn(1'b0, 32'h0000_1040, 32'h0000_1040, '0, LINE1, 0);
    chk("t1_line", bus.line_rdata, LINE1);

    // 2: write streams D0..D3, read buffer untouched
    noise = {8{$urandom}};
    do_txn(1'b1, 32'h0000_2000, 32'h0000_2000, WLINE, noise, 0);
    chk("t2_rdata_kept", bus.line_rdata, LINE1);

    // 3: read with two idle cycles between beats
    do_txn(1'b0, 32'h0000_3080, 32'h0000_3080, '0, LINE3, 2);
    chk("t3_line", bus.line_rdata, LINE3);

    // 4: unaligned address is line-aligned
    do_txn(1'b0, 32'h0000_105C, 32'h0000_1040, '0, LINE4, 0);
    chk("t4_line", bus.line_rdata, LINE4);

    // 5: read then write, re-requested the cycle after line_resp
    do_txn(1'b0, 32'h0000_5000, 32'h0000_5000, '0, LINE1, 1);
    noise = {8{$urandom}};
    do_txn(1'b1, 32'h0000_5020, 32'h0000_5020, WLINE, noise, 0);
    chk("t5_rdata_kept", bus.line_rdata, LINE1);

    // 6: reset after the third beat of a read aborts it
    bus.line_read = 1'b1;
    bus.line_address = 32'h0000_6000;
    @(posedge clk); #2;
    for (int k = 0; k < 3; k++) begin
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = LINE6[k*BW +: BW];
      @(posedge clk); #2;
    end
    rst = 1'b1;
    bus.line_read   = 1'b0;
    bus.burst_rdata = LINE6[3*BW +: BW];
    @(posedge clk); #2;
    chk("t6_burst_read", bus.burst_read, 1'b0);
    chk("t6_burst_write", bus.burst_write, 1'b0);
    chk("t6_line_resp", bus.line_resp, 1'b0);
    chk("t6_burst_address", bus.burst_address, '0);
    chk("t6_line_rdata", bus.line_rdata, '0);
    chk("t6_burst_wdata", bus.burst_wdata, '0);
    rst = 1'b0;
    bus.burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #2;
    bus.burst_resp = 1'b0;
    chk("t6_late_beat_ignored", bus.burst_read, 1'b0);
    chk("t6_no_resp", bus.line_resp, 1'b0);
    do_txn(1'b0, 32'h0000_7010, 32'h0000_7000, '0, LINE7, 0);
    chk("t6_recovery_line", bus.line_rdata, LINE7);

    repeat (3) @(posedge clk);
    #2;
    chk("resp_pulse_count", n_resp, exp_resp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
